uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's uart_tx and uses the same bit timing (5209 clk cycles per bit, 9600 baud at 50 MHz).
- It synchronises the asynchronous serial line and samples each bit at mid-period.
- It presents each received byte with a single-cycle valid strobe to the core-side consumer, for example a MMIO console register.
- It flags framing errors and waits out line breaks before re-arming.

Parameters:
- CLKS_PER_BIT, 5209: clk cycles per bit period. Legal range is >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division): cycles from the detected start edge to the start-bit mid-sample.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- data  out  8  last good received byte; held until the next good frame.
- valid  out  1  one-cycle strobe: data updated this cycle.
- frame_err  out  1  one-cycle strobe: stop bit sampled low, byte discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst_n is synchronous, active-low, and sampled on the clk rising edge.
  - Reset values: state=IDLE, counter=0, bit index=0, shift register=0, both synchroniser flops=1, data=8'h00, valid=0, frame_err=0, busy=0.
  - Reset asserted mid-frame aborts the frame immediately. No strobe is produced and no partial data reaches the data output.
- Input synchroniser:
  - rx passes through two flops to produce rx_s.
  - All decisions use rx_s only, never raw rx.
- Counter width: $clog2(CLKS_PER_BIT) bits, wide enough to hold CLKS_PER_BIT-1. It clears to 0 on every state transition.
- IDLE: if rx_s==0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1:
    - if rx_s==0, go to DATA with cnt=0 and bit index=0;
    - otherwise it is a glitch: return to IDLE with no strobe.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first: shift right and insert at bit 7. Increment bit index and clear cnt.
  - After the 8th sample (bit index 7), go to STOP.
- STOP, at cnt==CLKS_PER_BIT-1:
  - If rx_s==1: data<=shift register, valid=1 for exactly the next cycle, go to IDLE.
  - If rx_s==0: frame_err=1 for exactly the next cycle, data unchanged, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from being read as a stream of start bits.
- valid and frame_err are never asserted together and never held for more than one cycle.
- Latency: t0 is the clk edge at which rx is first captured low by the first synchroniser flop.
  - START is entered at edge t0+2.
  - DATA is entered at edge t0+2+HALF_BIT.
  - Bit k (k=0..7) is sampled at edge t0+2+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - The stop bit is sampled at edge t0+2+HALF_BIT+9*CLKS_PER_BIT. valid/frame_err are high in the cycle following that edge.
- Back-to-back frames: a start bit beginning one bit period after the previous stop-bit start is detected correctly, because IDLE is re-entered at mid-stop. Zero-gap streaming must not drop bytes.
- busy is a registered decode of state != IDLE.

Test Plan:
All scenarios use CLKS_PER_BIT=16, HALF_BIT=8, bit period 16 clk.
- Reset check: hold rst_n=0 for 5 cycles with rx=0, release with rx=1 -> data=8'h00, valid=0, frame_err=0, busy=0; no strobe within 200 cycles.
- Single byte: drive frame 0x A5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) from edge t0 -> exactly one valid pulse, in the cycle after edge t0+154; data=8'hA5 and held afterwards.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three valid pulses 160 cycles apart; data sequence 00, FF, 3C; frame_err never set.
- Glitch rejection: pulse rx low for 4 cycles, then high -> busy rises and returns to 0 by about t0+11; no valid or frame_err; a following 0x5A frame is received correctly.
- Framing error and break: send 0x81 with stop bit 0, then hold rx low for 100 cycles, then high -> one frame_err pulse; data keeps its prior value; no further strobes while low; a following 0x42 frame gives valid with data=8'h42.
- Mid-frame reset: assert rst_n=0 for 1 cycle during bit 4 of a frame -> state returns to IDLE and no strobe for that frame; the next full frame 0x99 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, a
// one-cycle valid strobe per good byte, a one-cycle frame_err strobe per
// bad stop bit, and a break hold that waits for the line to return high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5209,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            frame_err_reg, frame_err_next;
  logic            busy_reg;
  logic            rx_meta_reg;
  logic            rx_s;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      busy_reg      <= (state_next != IDLE);
    end
  end

  // Next-state logic: the counter clears on every state change, so each
  // state times its own interval from zero.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == CW'(HALF_BIT - 1)) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            // Start bit did not survive to mid-period: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DATA: begin
        if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      STOP: begin
        if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      BREAK: begin
        // Hold off until the line goes idle so a stuck-low line is not
        // mistaken for a stream of start bits.
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit. A reference model
// turns each transmitted frame into an expected strobe (kind, cycle, byte);
// a per-cycle monitor compares valid/frame_err/data against it.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int HB  = 8;
  // Start bit driven just after edge n -> captured at n+1 (t0);
  // stop bit sampled at t0+2+HB+9*CPB, strobe seen in the following cycle.
  localparam int STROBE_DELAY = 1 + 2 + HB + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         gap;
    bit         exp_valid;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        q[$];
  int         cyc = 0;
  bit         rst_seen = 1'b1;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_data;
  int         vectors = 0;
  int         miscompares = 0;
  bit         ev_v, ev_e;

  // Cycle counter and registered view of reset for the monitor.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  // Per-cycle monitor against the expected-strobe queue.
  initial begin
    forever begin
      @(negedge clk);
      ev_v = 1'b0;
      ev_e = 1'b0;
      if (rst_seen) begin
        model_data = 8'h00;
        q.delete();
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev_v = !q[0].is_err;
        ev_e = q[0].is_err;
        if (ev_v) model_data = q[0].b;
        void'(q.pop_front());
      end
      vectors++;
      if (valid !== ev_v || frame_err !== ev_e || data !== model_data) begin
        miscompares++;
        $display("FAIL strobe cyc=%0d: got valid=%b frame_err=%b data=%h, expected valid=%b frame_err=%b data=%h",
                 cyc, valid, frame_err, data, ev_v, ev_e, model_data);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame; caller is positioned just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit exp_v, input bit exp_e);
    logic [9:0] bits;
    ev_t e;
    bits = {stop, b, 1'b0};
    if (exp_v || exp_e) begin
      e.cyc    = cyc + STROBE_DELAY;
      e.is_err = exp_e;
      e.b      = b;
      q.push_back(e);
    end
    $display("frame %h stop=%0d at cyc %0d", b, stop, cyc);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic line_level(input logic lvl, input int n);
    rx = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl[5];

  initial begin
    int         n0;
    logic [7:0] rb;
    logic       rs;
    int         rg;

    tbl[0] = '{8'hA5, 1'b1, 30, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b1, 30, 1'b1, 1'b0, 8'h3C};
    tbl[4] = '{8'hC3, 1'b0, 20, 1'b0, 1'b1, 8'h3C};

    // Reset with the line low, release with it high.
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx    = 1'b1;
    chk("reset_data", data, 8'h00);
    chk("reset_valid", {7'd0, valid}, 8'h00);
    chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    line_level(1'b1, 200);
    chk("idle_busy", {7'd0, busy}, 8'h00);

    // Directed table: single byte, back-to-back stream, bad stop bit.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, tbl[i].exp_valid, tbl[i].exp_ferr);
      line_level(1'b1, tbl[i].gap);
      chk($sformatf("table%0d_data", i), data, tbl[i].exp_data);
    end
    exp_data = 8'h3C;

    // Glitch: 4 cycles low is rejected at the start-bit mid-sample.
    line_level(1'b1, 10);
    n0 = cyc;
    line_level(1'b0, 4);
    chk("glitch_busy_high", {7'd0, busy}, 8'h01);
    line_level(1'b1, 9);
    chk("glitch_busy_low", {7'd0, busy}, 8'h00);
    chk("glitch_elapsed", 8'(cyc - n0), 8'd13);
    line_level(1'b1, 10);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    line_level(1'b1, 20);
    exp_data = 8'h5A;
    chk("after_glitch_data", data, exp_data);

    // Framing error followed by a held-low line.
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    line_level(1'b0, 100);
    chk("break_data_held", data, exp_data);
    chk("break_busy", {7'd0, busy}, 8'h01);
    line_level(1'b1, 20);
    chk("break_exit_busy", {7'd0, busy}, 8'h00);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    line_level(1'b1, 20);
    exp_data = 8'h42;
    chk("after_break_data", data, exp_data);

    // Reset pulse during bit 4; upper bits of 0xF3 keep the line high
    // afterwards so the tail of the aborted frame cannot look like a start.
    fork
      send_frame(8'hF3, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) begin
          @(posedge clk);
          #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    exp_data = 8'h00;
    chk("midreset_data", data, exp_data);
    chk("midreset_busy", {7'd0, busy}, 8'h00);
    line_level(1'b1, 20);
    send_frame(8'h99, 1'b1, 1'b1, 1'b0);
    line_level(1'b1, 20);
    exp_data = 8'h99;
    chk("after_reset_data", data, exp_data);

    // Random frames; reference: good stop -> valid with the byte,
    // bad stop -> frame_err with data unchanged.
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      rg = rs ? int'($urandom_range(0, 30)) : int'($urandom_range(8, 30));
      send_frame(rb, rs, rs, !rs);
      line_level(1'b1, rg);
      if (rs) exp_data = rb;
      chk($sformatf("random%0d_data", i), data, exp_data);
    end

    line_level(1'b1, 20);
    chk("pending_events", 8'(q.size()), 8'd0);
    chk("final_busy", {7'd0, busy}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
